// File: rtl/clk_div_ctrl_if.sv
// rtl/clk_div_ctrl_if.sv - divisor configuration handshake for clk_div_ctrl
interface clk_div_ctrl_if #(
    parameter int DIV_W = 25
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - runtime-reconfigurable clock divider with glitch-free divisor change
// Optional edge counter output enabled by macro CLK_DIV_CTRL_EDGE_CNT_EN.
module clk_div_ctrl #(
    parameter int          DIV_W    = 25,
    parameter int unsigned DIV_INIT = 25_000_000
) (
    input  logic        clk_in,
    input  logic        rst,
    clk_div_ctrl_if.slave cfg,
    output logic        clk_out,
    output logic        tick,
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    output logic [15:0] edge_cnt,
`endif
    output logic        running
);

    localparam logic [DIV_W-1:0] INIT_DIV = DIV_INIT[DIV_W-1:0];

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_PEND
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] cur_div, cur_div_n;
    logic [DIV_W-1:0] pend_div, pend_div_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic             clk_out_n;
    logic             tick_n;
    logic             hs;
    logic             at_toggle;

    assign cfg.cfg_ready = (state != ST_PEND);
    assign running       = (state != ST_STOP);
    assign hs            = cfg.cfg_valid && cfg.cfg_ready;
    assign at_toggle     = (cnt == cur_div - DIV_W'(1));

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state    <= (INIT_DIV != '0) ? ST_RUN : ST_STOP;
            cur_div  <= INIT_DIV;
            pend_div <= '0;
            cnt      <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state    <= state_n;
            cur_div  <= cur_div_n;
            pend_div <= pend_div_n;
            cnt      <= cnt_n;
            clk_out  <= clk_out_n;
            tick     <= tick_n;
        end
    end

    always_comb begin
        state_n    = state;
        cur_div_n  = cur_div;
        pend_div_n = pend_div;
        cnt_n      = cnt;
        clk_out_n  = clk_out;
        tick_n     = 1'b0;
        case (state)
            ST_STOP: begin
                cnt_n     = '0;
                clk_out_n = 1'b0;
                if (hs && cfg.cfg_div != '0) begin
                    cur_div_n = cfg.cfg_div;
                    state_n   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (at_toggle) begin
                    cnt_n     = '0;
                    clk_out_n = ~clk_out;
                    tick_n    = ~clk_out;
                end else begin
                    cnt_n = cnt + DIV_W'(1);
                end
                // A divisor accepted on a toggle edge waits for the next toggle point
                if (hs) begin
                    pend_div_n = cfg.cfg_div;
                    state_n    = ST_PEND;
                end
            end
            ST_PEND: begin
                if (at_toggle) begin
                    cnt_n = '0;
                    if (pend_div != '0) begin
                        clk_out_n = ~clk_out;
                        tick_n    = ~clk_out;
                        cur_div_n = pend_div;
                        state_n   = ST_RUN;
                    end else begin
                        clk_out_n = 1'b0;
                        state_n   = ST_STOP;
                    end
                end else begin
                    cnt_n = cnt + DIV_W'(1);
                end
            end
            default: begin
                state_n = ST_STOP;
            end
        endcase
    end

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
        end else if (tick_n) begin
            edge_cnt <= edge_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - randomized bench for clk_div_ctrl against a toggle-schedule model
module tb_clk_div_ctrl;

    localparam int DIV_W    = 8;
    localparam int DIV_INIT = 3;

    logic clk_in = 1'b0;
    logic rst;
    logic clk_out;
    logic tick;
    logic running;
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    logic [15:0] edge_cnt;
`endif

    clk_div_ctrl_if #(.DIV_W(DIV_W)) cfg ();

    clk_div_ctrl #(
        .DIV_W   (DIV_W),
        .DIV_INIT(DIV_INIT)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .cfg     (cfg),
        .clk_out (clk_out),
        .tick    (tick),
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
        .edge_cnt(edge_cnt),
`endif
        .running (running)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: absolute edge index of the next toggle plus the pending request, if any
    int t = 0;
    bit m_stop;
    int m_half;
    int m_next;
    bit m_level;
    bit m_tick;
    bit m_pend;
    int m_pend_val;
    int m_edges;

    function automatic void model_reset();
        m_stop  = (DIV_INIT == 0);
        m_half  = DIV_INIT;
        m_next  = t + DIV_INIT;
        m_level = 1'b0;
        m_tick  = 1'b0;
        m_pend  = 1'b0;
        m_edges = 0;
    endfunction

    function automatic void model_edge(input bit v, input int d);
        bit hs;
        hs     = v && !m_pend;
        m_tick = 1'b0;
        if (m_stop) begin
            if (hs && d != 0) begin
                m_stop = 1'b0;
                m_half = d;
                m_next = t + d;
            end
        end else begin
            if (t == m_next) begin
                if (m_pend && m_pend_val == 0) begin
                    m_stop  = 1'b1;
                    m_level = 1'b0;
                    m_pend  = 1'b0;
                end else begin
                    if (m_pend) begin
                        m_half = m_pend_val;
                        m_pend = 1'b0;
                    end
                    m_level = !m_level;
                    m_tick  = m_level;
                    m_next  = t + m_half;
                end
            end
            if (hs) begin
                m_pend     = 1'b1;
                m_pend_val = d;
            end
        end
        if (m_tick) m_edges = (m_edges + 1) % 65536;
    endfunction

    task automatic compare_all(input string ctx);
        check({ctx, ".clk_out"},   clk_out,       m_level);
        check({ctx, ".tick"},      tick,          m_tick);
        check({ctx, ".cfg_ready"}, cfg.cfg_ready, !m_pend);
        check({ctx, ".running"},   running,       !m_stop);
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
        check({ctx, ".edge_cnt"},  edge_cnt,      m_edges);
`endif
    endtask

    task automatic reset_pulse(input int edges);
        @(negedge clk_in);
        rst = 1'b0;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = DIV_W'(1);
        #1;
        model_reset();
        compare_all("rst_async");
        for (int k = 0; k < edges; k++) begin
            @(posedge clk_in);
            t++;
            model_reset();
            #1;
            compare_all("rst_hold");
        end
        @(negedge clk_in);
        rst = 1'b1;
        cfg.cfg_valid = 1'b0;
    endtask

    task automatic step(input bit v, input int d);
        cfg.cfg_valid = v;
        cfg.cfg_div   = DIV_W'(d);
        @(posedge clk_in);
        t++;
        model_edge(v, d);
        #1;
        compare_all("run");
        @(negedge clk_in);
    endtask

    initial begin
        bit v;
        int d;
        rst           = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_div   = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_in);
            t++;
            model_reset();
        end
        @(negedge clk_in);
        compare_all("reset");
        rst = 1'b1;

        // Free run from DIV_INIT, then clk/2, then a stop request with a second offer
        for (int k = 0; k < 14; k++) step(1'b0, 0);
        step(1'b1, 1);
        for (int k = 0; k < 6; k++) step(1'b0, 0);
        step(1'b1, 4);
        for (int k = 0; k < 3; k++) step(1'b0, 0);
        step(1'b1, 0);
        step(1'b1, 2);
        for (int k = 0; k < 10; k++) step(1'b0, 0);
        step(1'b1, 2);
        for (int k = 0; k < 6; k++) step(1'b0, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) begin
                step(1'b1, 5);
                reset_pulse($urandom_range(1, 3));
            end
            v = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 9) < 2) ? 0 : int'($urandom_range(1, 6));
            step(v, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
